pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline controller for the five-stage MIPS core. It drives the per-stage register enables (`pc_ena`, `if_id_ena`, `id_exe_ena`, `exe_mem_ena`, `mem_wb_ena`), which the pipeline registers sample. It also drives the bubble and flush qualifiers those registers use to squash contents. It detects load-use hazards between the ID and EXE stages, freezes the pipeline while data memory is not ready, squashes the wrong-path fetch on a taken branch, and counts stall cycles.

## Interface
Parameters:
- MEM_TIMEOUT, 255, number of MEM_WAIT cycles after which `mem_timeout` sets.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- id_rs_addr  in  5  rs field of the instruction in ID.
- id_rt_addr  in  5  rt field of the instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- exe_GPR_we  in  1  write enable held in ID/EXE.
- exe_GPR_waddr  in  5  destination held in ID/EXE.
- exe_GPR_wdata_select  in  2  writeback source held in ID/EXE.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_ena  out  1  PC update enable.
- if_id_ena  out  1  IF/ID register enable.
- id_exe_ena  out  1  ID/EXE register enable.
- exe_mem_ena  out  1  EXE/MEM register enable.
- mem_wb_ena  out  1  MEM/WB register enable.
- id_exe_bubble  out  1  when set, ID/EXE loads a NOP with GPR_we=0.
- if_id_flush  out  1  when set, IF/ID loads instruction 0x00000000.
- stall_cycles  out  32  saturating count of cycles with `pc_ena`=0.
- mem_timeout  out  1  sticky; MEM_WAIT lasted MEM_TIMEOUT cycles.

## Operation
- States: RUN, MEM_WAIT. The state is registered; all enable, bubble and flush outputs are combinational from the state and the inputs.
- **Load-use hazard** = `exe_GPR_we` & (`exe_GPR_wdata_select`==WSEL_MEM) & (`exe_GPR_waddr`!=0) & ((`id_rs_used` & rs==waddr) | (`id_rt_used` & rt==waddr)).
- **Memory stall** = `mem_req` & !`mem_ready`.
- **Priority:** memory stall > load-use > branch flush.
- **RUN, memory stall:**
  - All five enables are 0; bubble and flush are 0.
  - Next state is MEM_WAIT.
- **RUN, load-use hazard:**
  - `pc_ena`=0, `if_id_ena`=0.
  - `id_exe_ena`=1 with `id_exe_bubble`=1.
  - `exe_mem_ena`=1, `mem_wb_ena`=1.
  - `if_id_flush`=0, because the branch is not yet resolved.
  - Exactly one bubble is inserted per load; the next cycle re-evaluates with the load in MEM.
- **RUN, `id_branch_taken` and no hazard:** all enables are 1 and `if_id_flush`=1.
- **RUN, otherwise:** all enables are 1; bubble and flush are 0.
- **MEM_WAIT, `mem_ready`=0:**
  - All enables are 0.
  - The wait counter increments, saturating at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, `mem_timeout` sets and stays set until reset.
  - The FSM keeps waiting.
- **MEM_WAIT, `mem_ready`=1:**
  - Outputs are evaluated exactly as in RUN minus the memory-stall term, so a load-use hazard or flush still applies.
  - Next state is RUN and the wait counter clears.
- **stall_cycles:** +1 on every clock edge where `pc_ena`=0; holds at 0xFFFFFFFF.

## Timing
- Zero-cycle control latency: the enables are valid in the same cycle as the hazard inputs and are sampled by the pipeline registers at the next rising edge.
- A load-use stall costs exactly 1 cycle.
- A memory stall lasting N cycles with `mem_ready`=0 freezes the pipeline for N cycles. The completing cycle (`mem_ready`=1) advances.
- **While `reset`=1** (asynchronous, independent of clk):
  - state=RUN, wait counter=0, `stall_cycles`=0, `mem_timeout`=0.
  - All enables=0, `id_exe_bubble`=0, `if_id_flush`=0.
- **Reset asserted mid-MEM_WAIT:** the FSM aborts to RUN immediately. The first edge after deassertion uses RUN rules.
- A `mem_ready` pulse while in RUN without `mem_req` is ignored.

## Structure
- Shared package `pipeline_pkg`:
  - WSEL_ALU=2'b00, WSEL_MEM=2'b01, WSEL_LINK=2'b10.
  - State encoding RUN=1'b0, MEM_WAIT=1'b1.
- One sub-module, `load_use_detect`: purely combinational hazard compare. The FSM, counters and output logic stay in the top level.

## Test plan
- **Load-use:** lw to $8 sits in EXE (we=1, wsel=01, waddr=8); ID reads rs=8 with rs_used=1 → one cycle of pc_ena=0, if_id_ena=0, id_exe_bubble=1; stall_cycles=1; the next cycle has all enables=1.
- **Non-hazards:**
  - waddr=0 with rs=0 → no stall.
  - wsel=00 (ALU op) to $8 with rs=8 → no stall (forwarding case).
  - rt=8 but rt_used=0 → no stall.
- **Memory stall:** mem_req=1 with mem_ready=0 for 3 cycles, then 1 → enables are 0 for 3 cycles and 1 in the 4th; stall_cycles=3; state returns to RUN.
- **Priority:** memory stall, load-use and branch_taken all asserted in one cycle → all enables 0, bubble=0, flush=0. After mem_ready, the load-use bubble is applied with flush=0.
- **Timeout:** MEM_TIMEOUT=4 with mem_ready held 0 for 6 cycles → mem_timeout=1 from the 4th wait edge and stays 1 after mem_ready. It clears only when reset pulses.
- **Reset mid-wait:** assert reset asynchronously in MEM_WAIT → outputs go to reset values before the next clk edge; after release, a normal instruction gives all enables=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: writeback-source codes and controller state encoding shared by the pipeline.
package pipeline_pkg;
  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads a register still being loaded in EXE.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       we_i,
  input  logic [1:0] wsel_i,
  input  logic [4:0] waddr_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       rs_used_i,
  input  logic       rt_used_i,
  output logic       hazard_o
);
  assign hazard_o = we_i && wsel_i == WSEL_MEM && waddr_i != 5'd0 &&
                    ((rs_used_i && rs_i == waddr_i) || (rt_used_i && rt_i == waddr_i));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage enables, bubble/flush qualifiers and stall accounting for the
// five-stage core; freezes on data-memory waits, bubbles load-use hazards, squashes taken-branch fetch.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_branch_taken,
  input  logic        exe_GPR_we,
  input  logic [4:0]  exe_GPR_waddr,
  input  logic [1:0]  exe_GPR_wdata_select,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        id_exe_ena,
  output logic        exe_mem_ena,
  output logic        mem_wb_ena,
  output logic        id_exe_bubble,
  output logic        if_id_flush,
  output logic [31:0] stall_cycles,
  output logic        mem_timeout
);
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   stall_q, stall_d;
  logic          timeout_q, timeout_d;
  logic          lu, freeze, waiting, adv;
  load_use_detect u_lu (
    .we_i      (exe_GPR_we),
    .wsel_i    (exe_GPR_wdata_select),
    .waddr_i   (exe_GPR_waddr),
    .rs_i      (id_rs_addr),
    .rt_i      (id_rt_addr),
    .rs_used_i (id_rs_used),
    .rt_used_i (id_rt_used),
    .hazard_o  (lu)
  );
  // In MEM_WAIT the outstanding access keeps us frozen even if mem_req drops.
  assign freeze  = (state_q == MEM_WAIT || mem_req) && !mem_ready;
  assign waiting = state_q == MEM_WAIT && !mem_ready;
  assign adv     = !reset && !freeze;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  always_comb state_d = freeze ? MEM_WAIT : RUN;
  always_comb begin
    pc_ena        = adv && !lu;
    if_id_ena     = adv && !lu;
    id_exe_ena    = adv;
    exe_mem_ena   = adv;
    mem_wb_ena    = adv;
    id_exe_bubble = adv && lu;
    if_id_flush   = adv && !lu && id_branch_taken;
  end
  always_comb begin
    wait_d    = waiting ? (wait_q == CW'(MEM_TIMEOUT) ? wait_q : wait_q + 1'b1) : '0;
    timeout_d = timeout_q || wait_d == CW'(MEM_TIMEOUT);
    stall_d   = (!pc_ena && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  assign stall_cycles = stall_q;
  assign mem_timeout  = timeout_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vectors with hand-computed enable patterns and stall counts.
module tb_pipeline_stall_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, waddr;
  logic        rsu, rtu, br, we, req, rdy;
  logic [1:0]  wsel;
  logic        pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena, id_exe_bubble, if_id_flush;
  logic [31:0] stall_cycles;
  logic        mem_timeout;
  logic [6:0]  ctl;
  int          errs = 0;
  int          checks = 0;
  int          exp_stall = 0;
  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] LU   = 7'b0011110;
  localparam logic [6:0] BR   = 7'b1111101;
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(rs), .id_rt_addr(rt), .id_rs_used(rsu), .id_rt_used(rtu),
    .id_branch_taken(br), .exe_GPR_we(we), .exe_GPR_waddr(waddr),
    .exe_GPR_wdata_select(wsel), .mem_req(req), .mem_ready(rdy),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .id_exe_ena(id_exe_ena),
    .exe_mem_ena(exe_mem_ena), .mem_wb_ena(mem_wb_ena),
    .id_exe_bubble(id_exe_bubble), .if_id_flush(if_id_flush),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );
  assign ctl = {pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena, id_exe_bubble, if_id_flush};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic setv(input logic w, input logic [1:0] ws, input logic [4:0] wa, input logic [4:0] s,
                      input logic [4:0] t, input logic su, input logic tu, input logic b,
                      input logic q, input logic d);
    we = w; wsel = ws; waddr = wa; rs = s; rt = t; rsu = su; rtu = tu; br = b; req = q; rdy = d;
  endtask
  // Check the combinational controls mid-cycle, clock once, then check the stall count.
  task automatic step(input string tag, input logic [6:0] ectl);
    #2 chk(tag, {25'd0, ctl}, {25'd0, ectl});
    @(posedge clk);
    #1;
    if (!ectl[6]) exp_stall++;
    chk({tag, "_stall"}, stall_cycles, exp_stall);
  endtask
  initial begin
    reset = 1'b1;
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("rst_ctl", {25'd0, ctl}, 32'd0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_to", {31'd0, mem_timeout}, 0);
    @(negedge clk) reset = 1'b0;
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);               step("normal", RUNV);
    setv(1, 2'b01, 8, 8, 3, 1, 0, 0, 0, 0);               step("lu_rs", LU);
    setv(0, 2'b00, 0, 8, 3, 1, 0, 0, 0, 0);               step("lu_after", RUNV);
    setv(1, 2'b01, 0, 0, 0, 1, 1, 0, 0, 0);               step("nh_r0", RUNV);
    setv(1, 2'b00, 8, 8, 0, 1, 0, 0, 0, 0);               step("nh_alu", RUNV);
    setv(1, 2'b01, 8, 1, 8, 1, 0, 0, 0, 0);               step("nh_rtunused", RUNV);
    setv(1, 2'b01, 8, 1, 8, 1, 1, 0, 0, 0);               step("lu_rt", LU);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);               step("branch", BR);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);               step("rdy_norq", RUNV);
    for (int i = 0; i < 3; i++) begin
      setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);             step("mwait", FRZ);
    end
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);               step("mdone", RUNV);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);               step("mrun", RUNV);
    chk("mto_clear", {31'd0, mem_timeout}, 0);
    setv(1, 2'b01, 8, 8, 0, 1, 0, 1, 1, 0);               step("prio_frz", FRZ);
    setv(1, 2'b01, 8, 8, 0, 1, 0, 1, 1, 1);               step("prio_lu", LU);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);               step("prio_run", RUNV);
    for (int i = 0; i < 6; i++) begin
      setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);             step("to_wait", FRZ);
      chk($sformatf("to_flag%0d", i), {31'd0, mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
    end
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);               step("to_done", RUNV);
    chk("to_sticky", {31'd0, mem_timeout}, 1);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);               step("to_run", RUNV);
    chk("to_sticky2", {31'd0, mem_timeout}, 1);
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);               step("rw_wait", FRZ);
    #1 reset = 1'b1;
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rw_ctl", {25'd0, ctl}, 32'd0);
    chk("rw_stall", stall_cycles, 0);
    chk("rw_to", {31'd0, mem_timeout}, 0);
    exp_stall = 0;
    @(negedge clk) reset = 1'b0;
    setv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);               step("rw_run", RUNV);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
